// File: rtl/fetch_sequencer.sv
// Instruction fetch front end for the 6502 core: loads PC from the reset vector, fetches
// opcode and operand bytes over a wait-stated bus, and issues whole instructions to execute.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RST_VEC  = 16'hFFFC,
    parameter int unsigned       WAIT_MAX = 16,
    parameter int unsigned       TMO_W    = 5
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        dec_op,
    input  logic [1:0]        dec_len,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [7:0]        ins_opcode,
    output logic [15:0]       ins_operand,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        StVecLo, StVecHi, StFetch, StDecode, StOpnd1, StOpnd2, StIssue, StError
    } state_e;

    localparam logic [ADDR_W-1:0] VecHiAddr = RST_VEC + ADDR_W'(1);
    localparam logic [TMO_W-1:0]  WaitLast  = TMO_W'(WAIT_MAX - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [7:0]        lsb_q, lsb_d;
    logic [7:0]        msb_q, msb_d;
    logic [1:0]        len_q, len_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [TMO_W-1:0]  wait_q, wait_d;
    logic              done;
    logic              redirect;

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = pc_q;
        case (state_q)
            StVecLo: begin
                mem_req  = 1'b1;
                mem_addr = RST_VEC;
            end
            StVecHi: begin
                mem_req  = 1'b1;
                mem_addr = VecHiAddr;
            end
            StFetch, StOpnd1, StOpnd2: mem_req = 1'b1;
            default: ;
        endcase
    end

    assign done     = mem_req && mem_ready;
    assign redirect = br_valid && (state_q != StVecLo) && (state_q != StVecHi) &&
                      (state_q != StError);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ins_pc_d   = ins_pc_q;
        ir_d       = ir_q;
        lsb_d      = lsb_q;
        msb_d      = msb_q;
        len_d      = len_q;
        err_code_d = err_code_q;
        wait_d     = wait_q;

        unique case (state_q)
            StVecLo: if (done) begin
                pc_d[7:0] = mem_rdata;
                state_d   = StVecHi;
            end
            StVecHi: if (done) begin
                pc_d    = ADDR_W'({mem_rdata, pc_q[7:0]});
                state_d = StFetch;
            end
            StFetch: if (done) begin
                ir_d     = mem_rdata;
                ins_pc_d = pc_q;
                pc_d     = pc_q + ADDR_W'(1);
                lsb_d    = 8'h00;
                msb_d    = 8'h00;
                state_d  = StDecode;
            end
            StDecode: begin
                len_d = dec_len;
                unique case (dec_len)
                    2'd0: state_d = StIssue;
                    2'd3: begin
                        state_d    = StError;
                        err_code_d = 2'b01;
                    end
                    default: state_d = StOpnd1;
                endcase
            end
            StOpnd1: if (done) begin
                lsb_d   = mem_rdata;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = (len_q == 2'd2) ? StOpnd2 : StIssue;
            end
            StOpnd2: if (done) begin
                msb_d   = mem_rdata;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = StIssue;
            end
            StIssue: if (ins_ready) state_d = StFetch;
            StError: ;
        endcase

        // A stalled read times out when this wait cycle would be the WAIT_MAX-th.
        if (mem_req && !mem_ready) begin
            wait_d = wait_q + TMO_W'(1);
            if ((WAIT_MAX != 0) && (wait_q == WaitLast)) begin
                state_d    = StError;
                err_code_d = 2'b10;
            end
        end

        // Redirect wins over any completion or accept in the same cycle.
        if (redirect) begin
            state_d    = StFetch;
            pc_d       = br_target;
            ins_pc_d   = ins_pc_q;
            ir_d       = ir_q;
            lsb_d      = lsb_q;
            msb_d      = msb_q;
            len_d      = len_q;
            err_code_d = err_code_q;
        end

        if (done || redirect || (state_d != state_q)) wait_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StVecLo;
            pc_q       <= '0;
            ins_pc_q   <= '0;
            ir_q       <= 8'h00;
            lsb_q      <= 8'h00;
            msb_q      <= 8'h00;
            len_q      <= 2'd0;
            err_code_q <= 2'b00;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ins_pc_q   <= ins_pc_d;
            ir_q       <= ir_d;
            lsb_q      <= lsb_d;
            msb_q      <= msb_d;
            len_q      <= len_d;
            err_code_q <= err_code_d;
            wait_q     <= wait_d;
        end
    end

    assign dec_op      = ir_q;
    assign ins_valid   = (state_q == StIssue);
    assign ins_opcode  = ir_q;
    assign ins_operand = {msb_q, lsb_q};
    assign ins_pc      = ins_pc_q;
    assign err         = (state_q == StError);
    assign err_code    = err_code_q;

endmodule
